// File: rtl/modbus_master_pkg.sv
// Shared MODBUS RTU constants, request payload and engine state encoding.
package modbus_master_pkg;

    localparam logic [7:0] FC_READ       = 8'h03;
    localparam logic [7:0] FC_WRITE      = 8'h06;
    localparam logic [7:0] EXC_BIT       = 8'h80;
    localparam logic [7:0] RD_BYTE_COUNT = 8'h02;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    localparam logic [3:0] LEN_READ  = 4'd7;
    localparam logic [3:0] LEN_WRITE = 4'd8;
    localparam logic [3:0] LEN_EXC   = 4'd5;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_TIMEOUT  = 3'd1;
    localparam logic [2:0] ST_CRC      = 3'd2;
    localparam logic [2:0] ST_EXC      = 3'd3;
    localparam logic [2:0] ST_MISMATCH = 3'd4;
    localparam logic [2:0] ST_RXERR    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_LOAD = 3'd1,
        S_TX_WAIT = 3'd2,
        S_RX      = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

    typedef struct packed {
        logic        write;
        logic [6:0]  slave;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

endpackage

// File: rtl/modbus_crc16.sv
// Byte-wide combinational CRC-16/MODBUS step.
module modbus_crc16
    import modbus_master_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc;

    // Eight reflected shift/xor steps, LSB first.
    always_comb begin
        crc = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            crc = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
        end
        crc_out = crc;
    end

endmodule

// File: rtl/modbus_master.sv
// MODBUS RTU master: sends one read/write request frame and validates the reply.
module modbus_master
    import modbus_master_pkg::*;
#(
    parameter int unsigned        TMOSIZE = 16,
    parameter logic [TMOSIZE-1:0] TMOMAX  = {TMOSIZE{1'b1}}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_slave,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        done,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_status,
    output logic [7:0]  tx_byte,
    output logic        send,
    input  logic        txbusy,
    input  logic [7:0]  rx_byte,
    input  logic        ready,
    input  logic        rxerr
);

    localparam logic [TMOSIZE-1:0] TMO_LAST = TMOMAX - TMOSIZE'(1);

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [2:0]         idx_q, idx_d;
    logic [15:0]        crc_q, crc_d, crc_next;
    logic [TMOSIZE-1:0] tmo_q, tmo_d;
    logic [3:0]         rx_cnt_q, rx_cnt_d;
    logic               exc_q, exc_d, mism_q, mism_d, fdone_q, fdone_d;
    logic [15:0]        data_q, data_d;
    logic               req_ready_q, req_ready_d, done_q, done_d, send_q, send_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic [2:0]         rsp_status_q, rsp_status_d;
    logic               fin;
    logic [2:0]         fin_status;
    logic [15:0]        fin_data;
    logic [7:0]         tx_fb, fc, crc_byte;
    logic [3:0]         rx_len;

    // Request frame byte i; bytes 6/7 come from the running CRC.
    function automatic logic [7:0] frame_byte(input req_t r, input logic [2:0] i,
                                              input logic [15:0] crc);
        logic [7:0] b;
        case (i)
            3'd0:    b = {1'b0, r.slave};
            3'd1:    b = r.write ? FC_WRITE : FC_READ;
            3'd2:    b = r.addr[15:8];
            3'd3:    b = r.addr[7:0];
            3'd4:    b = r.write ? r.wdata[15:8] : 8'h00;
            3'd5:    b = r.write ? r.wdata[7:0]  : 8'h01;
            3'd6:    b = crc[7:0];
            default: b = crc[15:8];
        endcase
        return b;
    endfunction

    assign tx_fb    = frame_byte(req_q, idx_q, crc_q);
    assign fc       = req_q.write ? FC_WRITE : FC_READ;
    assign rx_len   = exc_q ? LEN_EXC : (req_q.write ? LEN_WRITE : LEN_READ);
    assign crc_byte = (state_q == S_RX) ? rx_byte : tx_fb;

    modbus_crc16 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    // Next-state, transmit sequencing and response checking.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        idx_d        = idx_q;
        crc_d        = crc_q;
        tmo_d        = tmo_q;
        rx_cnt_d     = rx_cnt_q;
        exc_d        = exc_q;
        mism_d       = mism_q;
        fdone_d      = fdone_q;
        data_d       = data_q;
        req_ready_d  = req_ready_q;
        done_d       = 1'b0;
        send_d       = 1'b0;
        tx_byte_d    = tx_byte_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        fin          = 1'b0;
        fin_status   = ST_OK;
        fin_data     = 16'h0000;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d       = '{write: req_write, slave: req_slave,
                                    addr: req_addr, wdata: req_wdata};
                    req_ready_d = 1'b0;
                    idx_d       = 3'd0;
                    crc_d       = CRC_INIT;
                    if (!req_write && req_slave == 7'd0) begin
                        fin        = 1'b1;
                        fin_status = ST_MISMATCH;
                    end else begin
                        state_d = S_TX_LOAD;
                    end
                end
            end
            S_TX_LOAD: begin
                if (!txbusy) begin
                    send_d    = 1'b1;
                    tx_byte_d = tx_fb;
                    if (idx_q < 3'd6) crc_d = crc_next;
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // send_q marks the first wait cycle, before the UART can raise txbusy.
                if (!send_q && !txbusy) begin
                    if (idx_q == 3'd7) begin
                        if (req_q.slave == 7'd0) begin
                            fin = 1'b1;
                        end else begin
                            state_d  = S_RX;
                            tmo_d    = '0;
                            rx_cnt_d = 4'd0;
                            exc_d    = 1'b0;
                            mism_d   = 1'b0;
                            fdone_d  = 1'b0;
                            crc_d    = CRC_INIT;
                            data_d   = 16'h0000;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_TX_LOAD;
                    end
                end
            end
            S_RX: begin
                if (rxerr) begin
                    fin        = 1'b1;
                    fin_status = ST_RXERR;
                end else if (fdone_q) begin
                    fin = 1'b1;
                    if (crc_q != 16'h0000)  fin_status = ST_CRC;
                    else if (mism_q)        fin_status = ST_MISMATCH;
                    else if (exc_q)         fin_status = ST_EXC;
                    else                    fin_status = ST_OK;
                    if (fin_status == ST_OK || fin_status == ST_EXC) fin_data = data_q;
                end else if (ready) begin
                    tmo_d    = '0;
                    crc_d    = crc_next;
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    fdone_d  = (rx_cnt_d == rx_len);
                    if (rx_cnt_q == 4'd0) begin
                        if (rx_byte != {1'b0, req_q.slave}) mism_d = 1'b1;
                    end else if (rx_cnt_q == 4'd1) begin
                        if (rx_byte == (fc | EXC_BIT)) exc_d = 1'b1;
                        else if (rx_byte != fc)        mism_d = 1'b1;
                    end else if (exc_q) begin
                        if (rx_cnt_q == 4'd2) data_d = {8'h00, rx_byte};
                    end else if (req_q.write) begin
                        if (rx_cnt_q < 4'd6 &&
                            rx_byte != frame_byte(req_q, rx_cnt_q[2:0], crc_q)) mism_d = 1'b1;
                        if (rx_cnt_q == 4'd4) data_d[15:8] = rx_byte;
                        if (rx_cnt_q == 4'd5) data_d[7:0]  = rx_byte;
                    end else begin
                        if (rx_cnt_q == 4'd2 && rx_byte != RD_BYTE_COUNT) mism_d = 1'b1;
                        if (rx_cnt_q == 4'd3) data_d[15:8] = rx_byte;
                        if (rx_cnt_q == 4'd4) data_d[7:0]  = rx_byte;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fin        = 1'b1;
                    fin_status = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMOSIZE'(1);
                end
            end
            S_FINISH: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d      = S_FINISH;
            done_d       = 1'b1;
            rsp_status_d = fin_status;
            rsp_data_d   = fin_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            idx_q        <= 3'd0;
            crc_q        <= CRC_INIT;
            tmo_q        <= '0;
            rx_cnt_q     <= 4'd0;
            exc_q        <= 1'b0;
            mism_q       <= 1'b0;
            fdone_q      <= 1'b0;
            data_q       <= 16'h0000;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            send_q       <= 1'b0;
            tx_byte_q    <= 8'h00;
            rsp_data_q   <= 16'h0000;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            tmo_q        <= tmo_d;
            rx_cnt_q     <= rx_cnt_d;
            exc_q        <= exc_d;
            mism_q       <= mism_d;
            fdone_q      <= fdone_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            send_q       <= send_d;
            tx_byte_q    <= tx_byte_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign send       = send_q;
    assign tx_byte    = tx_byte_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: doc/modbus_master.md
# modbus_master

MODBUS RTU master (initiator) transaction engine: the other end of the link from the slave endpoint. Accepts single-register read (function 0x03) or write (function 0x06) requests from local logic, serialises the request frame with CRC-16 to a byte-level UART, and receives and validates the slave's response. It returns the data and a status code. It sits between a local controller and the existing `uart` block, wired to `din`/`send`/`txbusy` and `dout`/`ready`/`rxerr`.

## Interface
- `TMOSIZE`, 16: width of the response-timeout counter.
- `TMOMAX`, {TMOSIZE{1'b1}}: clock cycles of receive silence that end a transaction with a timeout.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: request strobe; accepted only when `req_ready`=1.
- `req_ready` out 1: engine idle.
- `req_write` in 1: 1 selects write (0x06); 0 selects read (0x03).
- `req_slave` in 7: slave address; 0 is broadcast.
- `req_addr` in 16: register address.
- `req_wdata` in 16: write value.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `rsp_data` out 16: read data; holds the exception code in [7:0] on status 3.
- `rsp_status` out 3: 0 OK, 1 timeout, 2 CRC error, 3 exception, 4 mismatch, 5 UART rx error.
- `tx_byte` out 8: to UART `din`.
- `send` out 1: to UART.
- `txbusy` in 1: from UART.
- `rx_byte` in 8: from UART `dout`.
- `ready` in 1: from UART; one-cycle byte strobe.
- `rxerr` in 1: from UART.

## Operation
- Reset values: `req_ready`=1, `done`=0, `send`=0, `tx_byte`=0, `rsp_data`=0, `rsp_status`=0. A reset mid-transaction aborts it; no `done` pulse is issued.
- States:
  - IDLE: waits for `req_valid`&`req_ready`, then latches all `req_*` fields.
  - TX_LOAD: drives the next frame byte.
  - TX_WAIT: waits for the UART to finish the byte.
  - RX: collects response bytes.
  - FINISH: raises `done`, then returns to IDLE.
- Request frame is 8 bytes: slave, fc, addrHi, addrLo, then (read) 0x00, 0x01 or (write) dataHi, dataLo, then crcLo, crcHi.
- CRC: CRC-16/MODBUS, init 0xFFFF, reflected polynomial 0xA001, one byte per cycle, low byte transmitted first.
- Broadcast:
  - Write to slave 0 finishes with status 0 right after the last TX byte, without entering RX.
  - Read to slave 0 goes straight to FINISH with status 4; nothing is transmitted.
- Expected response:
  - Read: slave, 0x03, 0x02, dHi, dLo, crcLo, crcHi (7 bytes).
  - Write: exact echo of the 8 request bytes.
- Exception response: byte 1 = fc|0x80. The frame length becomes 5 bytes (slave, fc|0x80, code, crc×2). Result is status 3 with `rsp_data`={8'h00, code}.
- Checks, in priority order:
  1. `rxerr` during RX gives status 5 immediately.
  2. Once the frame is complete, a CRC residue ≠ 0 gives status 2.
  3. A wrong slave, fc, byte count or echo byte gives status 4.
  4. Otherwise status 0.
- Bytes arriving in IDLE or during TX are discarded. Bytes after frame completion are ignored.

## Timing
- Request accept: `req_ready` falls the cycle after acceptance.
- Transmit: TX_LOAD asserts `send` for exactly one cycle, and only while `txbusy`=0. The UART raises `txbusy` the cycle after `send`. TX_WAIT waits at least one cycle, then for `txbusy`=0.
- Timeout counter:
  - Cleared on RX entry and on each `ready` strobe.
  - Increments every cycle while in RX.
  - Reaching `TMOMAX` gives status 1.
  - A byte and the timeout in the same cycle: the byte wins.
- Result timing: `rsp_data` and `rsp_status` are valid in the `done` cycle and hold until the next `done`. `done` follows the final byte by 2 cycles (CRC update, then check).
- Throughput: at most one transaction in flight. `req_valid` while busy is ignored; no queueing.

## Structure
- Shared package holds:
  - Function codes: FC_READ=0x03, FC_WRITE=0x06, EXC_BIT=0x80.
  - CRC init and polynomial constants.
  - Status code constants and the state encoding.
- Sub-module `modbus_crc16`: byte-wide combinational CRC step (crc_in, byte → crc_out). It is reusable by the slave endpoint.

## Test plan
- Read: slave 1, addr 0 → TX bytes 01 03 00 00 00 01 84 0A. Bench replies 01 03 02 00 2A with correct CRC → `done`, status 0, `rsp_data`=0x002A.
- Write: slave 1, addr 1, data 3 → TX 01 06 00 01 00 03 98 0B. Bench echoes the same bytes → status 0.
- Read reply has a corrupted CRC low byte → status 2. Exception reply 01 83 02 plus CRC → status 3, `rsp_data`=0x0002.
- No reply → `done` exactly `TMOMAX` cycles after RX entry, status 1. Also assert `rxerr` mid-reply → status 5.
- Broadcast write to slave 0 → 8 bytes sent, then status 0 with no RX. Broadcast read → status 4 and zero `send` pulses.
- Reset asserted during TX byte 4 → all outputs at reset values, no `done`. Next request completes normally.
